ssp_arbiter: RTL and testbench

Two-client round-robin arbiter and sequencer for the synchronous serial port's bus-side interface (PSEL/PWRITE/PWDATA/PRDATA).
- Converts per-client write and read requests into single-cycle SSP strobes.
- Holds off writes while the transmit FIFO is full.
- Returns read data to the client that requested it.
- Sits between two on-chip masters and one SSP instance, clocked by PCLK.

---
 rtl/ssp_arb_pkg.sv | 21 ++
 rtl/ssp_rr_pick.sv | 32 +++
 rtl/ssp_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ssp_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ssp_arb_pkg.sv
// Shared constants, state encoding and helpers for the SSP two-client arbiter.
package ssp_arb_pkg;

  localparam int DATA_W     = 8;
  localparam int N_CLIENTS  = 2;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    RD_WAIT = 3'd3,
    RD_DONE = 3'd4
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/ssp_rr_pick.sv
// Combinational 2-way round-robin picker: the eligible client after last_grant wins.
module ssp_rr_pick
  import ssp_arb_pkg::*;
(
  input  logic [N_CLIENTS-1:0] eligible,
  input  logic                 last_grant,
  output logic                 grant_valid,
  output logic                 grant_id
);

  // Rotate priority so the client served last is considered last.
  always_comb begin
    grant_valid = |eligible;
    grant_id    = 1'b0;
    if (last_grant) begin
      if (eligible[0]) begin
        grant_id = 1'b0;
      end else if (eligible[1]) begin
        grant_id = 1'b1;
      end else begin
        grant_id = 1'b0;
      end
    end else begin
      if (eligible[1]) begin
        grant_id = 1'b1;
      end else begin
        grant_id = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ssp_arbiter.sv
// Two-client round-robin arbiter/sequencer driving single-cycle SSP bus strobes.
// Optional per-client completion counters are enabled by defining SSP_ARB_STATS_EN.
module ssp_arbiter #(
  parameter int DATA_W = ssp_arb_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              PCLK,
  input  logic              CLEAR_B,
  input  logic [1:0]        wr_req,
  input  logic [2*DATA_W-1:0] wr_data,
  output logic [1:0]        wr_ack,
  input  logic [1:0]        rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        rd_valid,
  output logic              PSEL,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              SSPTXINTR,
  input  logic              SSPRXINTR
`ifdef SSP_ARB_STATS_EN
  ,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_rd_cnt
`endif
);

  import ssp_arb_pkg::*;

  localparam int CNT_W = $clog2(RD_LAT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

  arb_state_e           state_r;
  arb_state_e           state_s;
  logic [CNT_W-1:0]     wait_cnt_r;
  logic [CNT_W-1:0]     wait_cnt_s;
  logic                 last_grant_r;
  logic [N_CLIENTS-1:0] eligible_s;
  logic                 grant_valid_s;
  logic                 grant_id_s;
  logic                 grant_s;
  logic                 grant_wr_s;
  logic                 sample_s;
  logic [DATA_W-1:0]    grant_byte_s;
  logic                 psel_s;
  logic                 pwrite_s;
  logic [1:0]           wr_ack_s;
  logic [1:0]           rd_valid_s;
  logic                 rx_full_unused_s;

  // RxFIFO-full is status only; reads are never masked by it.
  assign rx_full_unused_s = SSPRXINTR;

  assign eligible_s = (wr_req & {N_CLIENTS{~SSPTXINTR}}) | rd_req;

  ssp_rr_pick u_pick (
    .eligible    (eligible_s),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Next-state logic; requests are only looked at in IDLE.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    grant_s    = 1'b0;
    grant_wr_s = 1'b0;
    sample_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          grant_s    = 1'b1;
          grant_wr_s = wr_req[grant_id_s] & ~SSPTXINTR;
          if (grant_wr_s) begin
            state_s = WRITE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        state_s = IDLE;
      end
      READ: begin
        state_s    = RD_WAIT;
        wait_cnt_s = WAIT_LOAD;
      end
      RD_WAIT: begin
        if (wait_cnt_r == {CNT_W{1'b0}}) begin
          sample_s = 1'b1;
          state_s  = RD_DONE;
        end else begin
          wait_cnt_s = wait_cnt_r - CNT_W'(1);
          state_s    = RD_WAIT;
        end
      end
      RD_DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle, registered below.
  always_comb begin
    psel_s     = (state_s == WRITE) || (state_s == READ);
    pwrite_s   = (state_s == WRITE);
    wr_ack_s   = 2'b00;
    rd_valid_s = 2'b00;
    if (state_s == WRITE) begin
      wr_ack_s[grant_id_s] = 1'b1;
    end else begin
      wr_ack_s = 2'b00;
    end
    if (state_s == RD_DONE) begin
      rd_valid_s[last_grant_r] = 1'b1;
    end else begin
      rd_valid_s = 2'b00;
    end
    if (grant_id_s) begin
      grant_byte_s = wr_data[2*DATA_W-1:DATA_W];
    end else begin
      grant_byte_s = wr_data[DATA_W-1:0];
    end
  end

  // State, grant history and registered bus/client outputs.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_r      <= IDLE;
      wait_cnt_r   <= {CNT_W{1'b0}};
      last_grant_r <= 1'b1;
      PSEL         <= 1'b0;
      PWRITE       <= 1'b0;
      PWDATA       <= {DATA_W{1'b0}};
      wr_ack       <= 2'b00;
      rd_valid     <= 2'b00;
      rd_data      <= {DATA_W{1'b0}};
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      if (grant_s) begin
        last_grant_r <= grant_id_s;
      end
      // The write byte is captured at the grant edge so a dropped request still completes.
      if (grant_wr_s) begin
        PWDATA <= grant_byte_s;
      end
      PSEL     <= psel_s;
      PWRITE   <= pwrite_s;
      wr_ack   <= wr_ack_s;
      rd_valid <= rd_valid_s;
      if (sample_s) begin
        rd_data <= PRDATA;
      end
    end
  end

`ifdef SSP_ARB_STATS_EN
  // Per-client saturating counters of completed writes and reads.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      stat_wr_cnt <= 32'h0000_0000;
      stat_rd_cnt <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (wr_ack[i]) begin
          stat_wr_cnt[16*i +: 16] <= sat_inc16(stat_wr_cnt[16*i +: 16]);
        end
        if (rd_valid[i]) begin
          stat_rd_cnt[16*i +: 16] <= sat_inc16(stat_rd_cnt[16*i +: 16]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ssp_arbiter.sv
// Directed self-checking bench for ssp_arbiter (RD_LAT=1 and RD_LAT=3 instances).
module tb_ssp_arbiter;

  logic        PCLK;
  logic        CLEAR_B;
  logic [1:0]  wr_req, wr_ack, rd_req, rd_valid;
  logic [15:0] wr_data;
  logic [7:0]  rd_data, PWDATA, PRDATA;
  logic        PSEL, PWRITE, SSPTXINTR, SSPRXINTR;

  logic [1:0]  wr_req3, wr_ack3, rd_req3, rd_valid3;
  logic [15:0] wr_data3;
  logic [7:0]  rd_data3, PWDATA3, PRDATA3;
  logic        PSEL3, PWRITE3, SSPTXINTR3;

`ifdef SSP_ARB_STATS_EN
  logic [31:0] stat_wr_cnt, stat_rd_cnt, stat_wr_cnt3, stat_rd_cnt3;
`endif

  int n_checks = 0;
  int n_errors = 0;

  ssp_arbiter #(.DATA_W(8), .RD_LAT(1)) dut (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .PSEL(PSEL), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .SSPTXINTR(SSPTXINTR), .SSPRXINTR(SSPRXINTR)
`ifdef SSP_ARB_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt)
`endif
  );

  ssp_arbiter #(.DATA_W(8), .RD_LAT(3)) dut3 (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B),
    .wr_req(wr_req3), .wr_data(wr_data3), .wr_ack(wr_ack3),
    .rd_req(rd_req3), .rd_data(rd_data3), .rd_valid(rd_valid3),
    .PSEL(PSEL3), .PWRITE(PWRITE3), .PWDATA(PWDATA3), .PRDATA(PRDATA3),
    .SSPTXINTR(SSPTXINTR3), .SSPRXINTR(SSPRXINTR)
`ifdef SSP_ARB_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt3), .stat_rd_cnt(stat_rd_cnt3)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apply_reset();
    CLEAR_B = 1'b0;
    wr_req = 2'b00; rd_req = 2'b00; wr_data = 16'h0000; PRDATA = 8'h00;
    SSPTXINTR = 1'b0; SSPRXINTR = 1'b0;
    wr_req3 = 2'b00; rd_req3 = 2'b00; wr_data3 = 16'h0000; PRDATA3 = 8'h00;
    SSPTXINTR3 = 1'b0;
    tick();
    tick();
    CLEAR_B = 1'b1;
  endtask

  initial begin
    // Reset values
    CLEAR_B = 1'b0;
    wr_req = 2'b00; rd_req = 2'b00; wr_data = 16'h0000; PRDATA = 8'h00;
    SSPTXINTR = 1'b0; SSPRXINTR = 1'b0;
    wr_req3 = 2'b00; rd_req3 = 2'b00; wr_data3 = 16'h0000; PRDATA3 = 8'h00;
    SSPTXINTR3 = 1'b0;
    tick();
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_pwrite", 32'(PWRITE), 32'h0);
    check("rst_pwdata", 32'(PWDATA), 32'h0);
    check("rst_wr_ack", 32'(wr_ack), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    tick();
    CLEAR_B = 1'b1;

    // Single client-0 write
    wr_req = 2'b01; wr_data = 16'h00A5;
    tick();
    check("a_psel", 32'(PSEL), 32'h1);
    check("a_pwrite", 32'(PWRITE), 32'h1);
    check("a_pwdata", 32'(PWDATA), 32'hA5);
    check("a_wr_ack", 32'(wr_ack), 32'h1);
    wr_req = 2'b00;
    tick();
    check("a_psel_off", 32'(PSEL), 32'h0);
    check("a_wr_ack_off", 32'(wr_ack), 32'h0);

    // Both clients writing, alternating grants from client 0
    apply_reset();
    wr_req = 2'b11; wr_data = 16'h2211;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i % 2 == 0) begin
        check("b_psel", 32'(PSEL), 32'h1);
        check("b_pwdata", 32'(PWDATA), (i % 4 == 0) ? 32'h11 : 32'h22);
        check("b_wr_ack", 32'(wr_ack), (i % 4 == 0) ? 32'h1 : 32'h2);
      end else begin
        check("b_psel_gap", 32'(PSEL), 32'h0);
        check("b_wr_ack_gap", 32'(wr_ack), 32'h0);
      end
      if (i == 6) wr_req = 2'b00;
    end

    // TX FIFO full masks client 0 write; client 1 read proceeds (RD_LAT=1)
    SSPTXINTR = 1'b1; wr_req = 2'b01; wr_data = 16'h0077; rd_req = 2'b10; PRDATA = 8'h00;
    tick();
    check("c_psel", 32'(PSEL), 32'h1);
    check("c_pwrite", 32'(PWRITE), 32'h0);
    check("c_wr_ack", 32'(wr_ack), 32'h0);
    PRDATA = 8'h3C;
    tick();
    check("c_wait_psel", 32'(PSEL), 32'h0);
    check("c_wait_rd_valid", 32'(rd_valid), 32'h0);
    tick();
    check("c_rd_valid", 32'(rd_valid), 32'h2);
    check("c_rd_data", 32'(rd_data), 32'h3C);
    rd_req = 2'b00; SSPTXINTR = 1'b0; PRDATA = 8'h00;
    tick();
    check("c_idle_psel", 32'(PSEL), 32'h0);
    check("c_idle_rd_valid", 32'(rd_valid), 32'h0);
    tick();
    check("c_wr_psel", 32'(PSEL), 32'h1);
    check("c_wr_pwrite", 32'(PWRITE), 32'h1);
    check("c_wr_pwdata", 32'(PWDATA), 32'h77);
    check("c_wr_ack", 32'(wr_ack), 32'h1);
    check("c_rd_data_hold", 32'(rd_data), 32'h3C);
    wr_req = 2'b00;
    tick();

    // RD_LAT=3 instance: rd_valid 4 cycles after the strobe
    rd_req3 = 2'b01;
    tick();
    check("d3_psel", 32'(PSEL3), 32'h1);
    check("d3_pwrite", 32'(PWRITE3), 32'h0);
    PRDATA3 = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d3_wait_rd_valid", 32'(rd_valid3), 32'h0);
      check("d3_wait_psel", 32'(PSEL3), 32'h0);
    end
    tick();
    check("d3_rd_valid", 32'(rd_valid3), 32'h1);
    check("d3_rd_data", 32'(rd_data3), 32'h3C);
    rd_req3 = 2'b00; PRDATA3 = 8'h55;
    tick();
    check("d3_rd_valid_off", 32'(rd_valid3), 32'h0);
    check("d3_rd_data_hold", 32'(rd_data3), 32'h3C);

    // Reset during RD_WAIT aborts the read
    rd_req = 2'b01; PRDATA = 8'h5A;
    tick();
    check("e_read_psel", 32'(PSEL), 32'h1);
    tick();
    CLEAR_B = 1'b0;
    #1;
    check("e_psel", 32'(PSEL), 32'h0);
    check("e_rd_valid", 32'(rd_valid), 32'h0);
    check("e_rd_data", 32'(rd_data), 32'h0);
    #2;
    rd_req = 2'b00;
    CLEAR_B = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("e_no_rd_valid", 32'(rd_valid), 32'h0);
      check("e_no_psel", 32'(PSEL), 32'h0);
    end
    wr_req = 2'b11; wr_data = 16'h2211;
    tick();
    check("e_first_pwdata", 32'(PWDATA), 32'h11);
    check("e_first_wr_ack", 32'(wr_ack), 32'h1);
    wr_req = 2'b00;
    tick();

`ifdef SSP_ARB_STATS_EN
    // Completion counters: 3 client-0 writes, 2 client-1 reads, then saturation
    apply_reset();
    wr_req = 2'b01; wr_data = 16'h00A5;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 4) wr_req = 2'b00;
    end
    check("s_wr_cnt", stat_wr_cnt, 32'h0000_0003);
    rd_req = 2'b10; PRDATA = 8'h42;
    for (int i = 0; i < 7; i++) tick();
    rd_req = 2'b00;
    tick();
    check("s_rd_cnt", stat_rd_cnt, 32'h0002_0000);
    force dut.stat_wr_cnt = 32'h0000_FFFF;
    tick();
    release dut.stat_wr_cnt;
    wr_req = 2'b01;
    tick();
    wr_req = 2'b00;
    tick();
    check("s_wr_sat", stat_wr_cnt, 32'h0000_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
